// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: PC register, combinational imem request and a small
// in-order queue that hands {instr, pc, pc+step} to decode over valid/ready.
module fetch_queue_stage #(
  parameter int               XLEN     = 32,
  parameter int               PC_STEP  = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  output logic            imem_en_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            valid_d_o,
  input  logic            ready_d_i,
  output logic [XLEN-1:0] instr_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] pc_plus_d_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]  STEP_C  = XLEN'(PC_STEP);

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_next_seq;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [XLEN-1:0]  instr_mem   [DEPTH];
  logic [XLEN-1:0]  pc_mem      [DEPTH];
  logic [XLEN-1:0]  pc_plus_mem [DEPTH];

  logic             not_empty;
  logic             pop;
  logic             push;

  assign pc_next_seq = pc + STEP_C;
  assign not_empty   = (count != '0);
  assign pop         = not_empty & ready_d_i;

  // A full queue may still fetch when decode drains the head in the same cycle.
  assign push        = rst & ~redirect_i & ((count < DEPTH_C) | pop);

  assign imem_addr_o = pc;
  assign imem_en_o   = push;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect_i) begin
      pc <= redirect_pc_i;
    end else if (push) begin
      pc <= pc_next_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr]   <= imem_rdata_i;
      pc_mem[wr_ptr]      <= pc;
      pc_plus_mem[wr_ptr] <= pc_next_seq;
    end
  end

  always_comb begin
    valid_d_o   = not_empty;
    instr_d_o   = '0;
    pc_d_o      = '0;
    pc_plus_d_o = '0;
    if (not_empty) begin
      instr_d_o   = instr_mem[rd_ptr];
      pc_d_o      = pc_mem[rd_ptr];
      pc_plus_d_o = pc_plus_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: the imem model returns addr>>2 so every
// head instruction can be predicted from its PC.
module tb_fetch_queue_stage;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        valid_d;
  logic        ready_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus_d;

  int checks = 0;
  int errors = 0;
  int pushes;

  fetch_queue_stage #(
    .XLEN(32), .PC_STEP(4), .RESET_PC(32'h0), .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_i(redirect),
    .redirect_pc_i(redirect_pc),
    .imem_addr_o(imem_addr),
    .imem_en_o(imem_en),
    .imem_rdata_i(imem_rdata),
    .valid_d_o(valid_d),
    .ready_d_i(ready_d),
    .instr_d_o(instr_d),
    .pc_d_o(pc_d),
    .pc_plus_d_o(pc_plus_d)
  );

  assign imem_rdata = imem_addr >> 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic redir,
                               input logic [31:0] rpc, input logic rdy);
    rst         = r;
    redirect    = redir;
    redirect_pc = rpc;
    ready_d     = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] exp_pc);
    checkOutput({tag, " valid"}, {31'b0, valid_d}, 32'h1);
    checkOutput({tag, " pc"}, pc_d, exp_pc);
    checkOutput({tag, " instr"}, instr_d, exp_pc >> 2);
    checkOutput({tag, " pc_plus"}, pc_plus_d, exp_pc + 32'h4);
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, " valid"}, {31'b0, valid_d}, 32'h0);
    checkOutput({tag, " instr"}, instr_d, 32'h0);
    checkOutput({tag, " pc"}, pc_d, 32'h0);
    checkOutput({tag, " pc_plus"}, pc_plus_d, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: timeout reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; ready_d = 1'b1;

    $display("[TB] reset and streaming");
    tick();
    checkEmpty("reset");
    checkOutput("reset addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("first fetch en", {31'b0, imem_en}, 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkHead("stream", 32'(i * 4));
      tick();
    end

    $display("[TB] decode back-pressure");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    pushes = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_en) pushes++;
      tick();
    end
    checkOutput("stall pushes", 32'(pushes), 32'h2);
    checkOutput("stall en", {31'b0, imem_en}, 32'h0);
    checkOutput("stall addr", imem_addr, 32'h8);
    checkHead("stall head", 32'h0);

    $display("[TB] release and full throughput");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkHead("release", 32'(i * 4));
      checkOutput("full push en", {31'b0, imem_en}, 32'h1);
      checkOutput("full addr", imem_addr, 32'(i * 4 + 8));
      tick();
    end

    $display("[TB] redirect while full");
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
    checkOutput("redirect en", {31'b0, imem_en}, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkEmpty("after redirect");
    checkOutput("redirect addr", imem_addr, 32'h100);
    tick();
    checkHead("redirect head", 32'h100);

    $display("[TB] redirect to wrap boundary");
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap addr", imem_addr, 32'hFFFF_FFFC);
    checkOutput("wrap empty", {31'b0, valid_d}, 32'h0);
    tick();
    checkOutput("wrap head pc", pc_d, 32'hFFFF_FFFC);
    checkOutput("wrap pc_plus", pc_plus_d, 32'h0);
    checkOutput("wrap instr", instr_d, 32'h3FFF_FFFF);
    checkOutput("wrap next addr", imem_addr, 32'h0);

    $display("[TB] reset during stall with redirect");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b0);
    tick();
    checkEmpty("mid reset");
    checkOutput("mid reset addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkHead("post reset head", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
